// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit (master)
// and the instruction memory (slave).
interface instr_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// Sequential fetch stage: holds PC and IR, fetches over a req/ack bus, issues one
// decoded instruction at a time and computes the next PC from the control decisions.
module instr_fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  instr_fetch_unit_if.master  imem,
  input  logic                stall,
  input  logic                pcSource,
  input  logic                jump,
  output logic                valid,
  output logic [5:0]          Op,
  output logic [5:0]          funct,
  output logic [4:0]          rs,
  output logic [4:0]          rt,
  output logic [4:0]          rd,
  output logic signed [31:0]  signImm,
  output logic [31:0]         pc,
  output logic [31:0]         pcPlus4
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] ir;
  logic        ir_load;
  logic        pc_load;
  logic [31:0] pc_next;

  function automatic logic signed [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

  function automatic logic [31:0] branch_target(input logic [31:0] base,
                                                input logic signed [31:0] imm);
    return base + {imm[29:0], 2'b00};
  endfunction

  function automatic logic [31:0] jump_target(input logic [31:0] base,
                                              input logic [25:0] index);
    return {base[31:28], index, 2'b00};
  endfunction

  // Field decode is a pure slice of IR, so it keeps showing the last
  // instruction while valid is low.
  assign Op      = ir[31:26];
  assign rs      = ir[25:21];
  assign rt      = ir[20:16];
  assign rd      = ir[15:11];
  assign funct   = ir[5:0];
  assign signImm = sext16(ir[15:0]);
  assign pcPlus4 = pc + 32'd4;

  assign imem.addr = pc;

  always_comb begin
    pc_next = pcPlus4;
    if (jump)
      pc_next = jump_target(pcPlus4, ir[25:0]);
    else if (pcSource)
      pc_next = branch_target(pcPlus4, signImm);
  end

  always_comb begin
    state_next = state;
    imem.req   = 1'b0;
    valid      = 1'b0;
    ir_load    = 1'b0;
    pc_load    = 1'b0;
    case (state)
      IDLE: state_next = FETCH;
      FETCH: begin
        imem.req = 1'b1;
        if (imem.ack) begin
          ir_load    = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        valid = 1'b1;
        if (!stall) begin
          pc_load    = 1'b1;
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Control and architectural state share the asynchronous reset so an
  // aborted fetch leaves IR cleared and PC back at its reset address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc    <= PC_RESET;
      ir    <= 32'h0;
    end else begin
      state <= state_next;
      if (pc_load) pc <= pc_next;
      if (ir_load) ir <= imem.rdata;
    end
  end

endmodule
